// File: rtl/cslrpreg_if.sv
// Console-side bus of the RP register block: strobes, address and data.
// The console drives the master side; cslrpreg sits on the slave side.
interface cslrpreg_if;
  logic        cslREQ;
  logic        cslWR;
  logic        cslRD;
  logic [1:0]  cslADDR;
  logic [31:0] cslDATAI;
  logic [31:0] cslDATAO;

  modport master (
    output cslREQ, cslWR, cslRD,
    output cslADDR, cslDATAI,
    input  cslDATAO
  );

  modport slave (
    input  cslREQ, cslWR, cslRD,
    input  cslADDR, cslDATAI,
    output cslDATAO
  );
endinterface

// File: rtl/cslrpreg.sv
// Console-side RP register block: DPR/MOL/WRL masks, per-drive spin-up
// emulation and a tear-free 64-bit snapshot of the RP debug word.
module cslrpreg #(
  parameter int unsigned      CNTW      = 20,
  parameter logic [CNTW-1:0]  SPINUP    = 20'd500000,
  parameter logic [7:0]       RESET_DPR = 8'h01,
  parameter logic [7:0]       RESET_WRL = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  cslrpreg_if.slave   csl,
  output logic [7:0]  rpDPR,
  output logic [7:0]  rpMOL,
  output logic [7:0]  rpWRL,
  input  logic [0:63] rpDEBUG
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SPIN   = 2'd1;
  localparam logic [1:0] ONLINE = 2'd2;

  logic [7:0]      dpr_q, dpr_d;
  logic [7:0]      molr_q, molr_d;
  logic [7:0]      wrl_q, wrl_d;
  logic [7:0]      eff_d;
  logic [7:0]      pend;
  logic [1:0]      st_q [8];
  logic [1:0]      st_d [8];
  logic [CNTW-1:0] cnt_q [8];
  logic [CNTW-1:0] cnt_d [8];
  logic [31:0]     dato_q, dato_d;
  logic [0:63]     snap_q, snap_d;
  logic [31:0]     rdat;
  logic            wr_ctl;
  logic            rd;
  logic            unused_hi;

  assign unused_hi = ^csl.cslDATAI[31:24];

  assign wr_ctl = csl.cslREQ & csl.cslWR &
                  (csl.cslADDR == 2'd0);
  assign rd     = csl.cslREQ & csl.cslRD;

  always_comb begin
    dpr_d  = dpr_q;
    molr_d = molr_q;
    wrl_d  = wrl_q;
    if (wr_ctl) begin
      dpr_d  = csl.cslDATAI[7:0];
      molr_d = csl.cslDATAI[15:8];
      wrl_d  = csl.cslDATAI[23:16];
    end
  end

  // Sequencer follows the post-write request so drops act on the write edge
  assign eff_d = molr_d & dpr_d;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      if (!eff_d[i]) begin
        st_d[i]  = IDLE;
        cnt_d[i] = '0;
      end else begin
        unique case (1'b1)
          (st_q[i] == IDLE): begin
            st_d[i]  = SPIN;
            cnt_d[i] = SPINUP;
          end
          (st_q[i] == SPIN): begin
            if (cnt_q[i] != '0)
              cnt_d[i] = cnt_q[i] - 1'b1;
            else
              st_d[i] = ONLINE;
          end
          (st_q[i] == ONLINE): ;
          default: begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rpMOL[i] = (st_q[i] == ONLINE);
      pend[i]  = (st_q[i] == SPIN);
    end
  end

  always_comb begin
    rdat = '0;
    unique case (csl.cslADDR)
      2'd0: rdat = {8'h00, wrl_q, molr_q, dpr_q};
      2'd1: rdat = {16'h0000, rpMOL, pend};
      2'd2: rdat = rpDEBUG[32:63];
      2'd3: rdat = snap_q[0:31];
      default: rdat = '0;
    endcase
  end

  always_comb begin
    dato_d = dato_q;
    snap_d = snap_q;
    if (rd) begin
      dato_d = rdat;
      if (csl.cslADDR == 2'd2)
        snap_d = rpDEBUG;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dpr_q  <= RESET_DPR;
      molr_q <= '0;
      wrl_q  <= RESET_WRL;
      dato_q <= '0;
      snap_q <= '0;
      for (int i = 0; i < 8; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      dpr_q  <= dpr_d;
      molr_q <= molr_d;
      wrl_q  <= wrl_d;
      dato_q <= dato_d;
      snap_q <= snap_d;
      for (int i = 0; i < 8; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rpDPR        = dpr_q;
  assign rpWRL        = wrl_q;
  assign csl.cslDATAO = dato_q;

endmodule

// File: tb/tb_cslrpreg.sv
// Bench for cslrpreg: directed table, spin-up corner sequences and
// randomized traffic against an edge-count based reference model.
module tb_cslrpreg;
  localparam int SP = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rpDPR, rpMOL, rpWRL;
  logic [0:63] dbg;

  cslrpreg_if bus();

  cslrpreg #(
    .CNTW(20), .SPINUP(20'd10),
    .RESET_DPR(8'h01), .RESET_WRL(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .csl(bus),
    .rpDPR(rpDPR), .rpMOL(rpMOL), .rpWRL(rpWRL),
    .rpDEBUG(dbg)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Model: rpMOL[i] is on once the edge count reaches the rise edge
  // recorded when the effective request last went 0->1.
  int          cyc = 0;
  int          rise [8];
  logic [7:0]  m_dpr, m_req, m_wrl, m_eff;
  logic [31:0] m_dato;
  logic [0:63] m_snap;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at edge %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mol_now();
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = m_eff[i] && (cyc >= rise[i]);
    return r;
  endfunction

  function automatic logic [7:0] pend_now();
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = m_eff[i] && (cyc < rise[i]);
    return r;
  endfunction

  task automatic drv(logic req, logic wr, logic rd,
                     logic [1:0] a, logic [31:0] d);
    bus.cslREQ   = req;
    bus.cslWR    = wr;
    bus.cslRD    = rd;
    bus.cslADDR  = a;
    bus.cslDATAI = d;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic step();
    logic [31:0] rv;
    logic [7:0]  ne;
    @(posedge clk);
    if (!rst_n) begin
      m_dpr = 8'h01; m_req = 8'h00; m_wrl = 8'h00;
      m_eff = 8'h00; m_dato = '0; m_snap = '0;
    end else begin
      if (bus.cslREQ && bus.cslRD) begin
        rv = '0;
        case (bus.cslADDR)
          2'd0: rv = {8'h00, m_wrl, m_req, m_dpr};
          2'd1: rv = {16'h0, mol_now(), pend_now()};
          2'd2: rv = dbg[32:63];
          default: rv = m_snap[0:31];
        endcase
        if (bus.cslADDR == 2'd2) m_snap = dbg;
        m_dato = rv;
      end
      if (bus.cslREQ && bus.cslWR && bus.cslADDR == 2'd0)
        {m_wrl, m_req, m_dpr} = bus.cslDATAI[23:0];
    end
    cyc++;
    ne = m_req & m_dpr;
    for (int i = 0; i < 8; i++)
      if (ne[i] && !m_eff[i]) rise[i] = cyc + SP + 1;
    m_eff = ne;
    #1;
    chk("mdl_dato", bus.cslDATAO, m_dato);
    chk("mdl_dpr", {24'h0, rpDPR}, {24'h0, m_dpr});
    chk("mdl_mol", {24'h0, rpMOL}, {24'h0, mol_now()});
    chk("mdl_wrl", {24'h0, rpWRL}, {24'h0, m_wrl});
  endtask

  task automatic wait_rise(output int at);
    int k;
    at = -1;
    k = 0;
    while (rpMOL == 8'h00 && k < 40) begin
      step();
      k++;
    end
    if (rpMOL != 8'h00) at = cyc;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  a;
    logic [31:0] d;
    logic [63:0] dbg;
    logic [31:0] e_do;
    logic [7:0]  e_dpr;
    logic [7:0]  e_mol;
    logic [7:0]  e_wrl;
  } vec_t;

  vec_t tv [7];

  initial begin
    int   n0, at;
    logic [7:0] seen;

    tv[0] = '{1, 0, 0, 0, 64'h0, 32'h1, 8'h01, 0, 0};
    tv[1] = '{1, 0, 2, 0, 64'h0123456789ABCDEF,
              32'h89ABCDEF, 8'h01, 0, 0};
    tv[2] = '{1, 0, 3, 0, 64'h0, 32'h01234567, 8'h01, 0, 0};
    tv[3] = '{0, 1, 1, 32'hFFFFFFFF, 64'h0,
              32'h01234567, 8'h01, 0, 0};
    tv[4] = '{1, 1, 0, 32'h00800001, 64'h0,
              32'h1, 8'h01, 0, 8'h80};
    tv[5] = '{1, 0, 0, 0, 64'h0, 32'h00800001, 8'h01, 0, 8'h80};
    tv[6] = '{1, 0, 1, 0, 64'h0, 32'h0, 8'h01, 0, 8'h80};

    for (int i = 0; i < 8; i++) rise[i] = 0;
    dbg = '0;
    rst_n = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      drv(1'b1, tv[i].wr, tv[i].rd, tv[i].a, tv[i].d);
      dbg = tv[i].dbg;
      step();
      chk($sformatf("tv%0d_do", i), bus.cslDATAO, tv[i].e_do);
      chk($sformatf("tv%0d_dpr", i), {24'h0, rpDPR},
          {24'h0, tv[i].e_dpr});
      chk($sformatf("tv%0d_mol", i), {24'h0, rpMOL},
          {24'h0, tv[i].e_mol});
      chk($sformatf("tv%0d_wrl", i), {24'h0, rpWRL},
          {24'h0, tv[i].e_wrl});
    end
    idle();

    // Two drives spin up together
    drv(1, 1, 0, 0, 32'h0000_0303);
    step();
    n0 = cyc;
    chk("a_dpr", {24'h0, rpDPR}, 32'h3);
    drv(1, 0, 1, 1, 0);
    step();
    chk("a_stat_spin", bus.cslDATAO, 32'h3);
    idle();
    wait_rise(at);
    chk("a_mol", {24'h0, rpMOL}, 32'h3);
    chk("a_rise_lat", at - n0, 11);
    drv(1, 0, 1, 1, 0);
    step();
    chk("a_stat_on", bus.cslDATAO, 32'h300);

    // Abort spin-up by dropping the request at cycle 5
    drv(1, 1, 0, 0, 32'h0000_0003);
    step();
    chk("b_mol_off", {24'h0, rpMOL}, 32'h0);
    drv(1, 1, 0, 0, 32'h0000_0103);
    step();
    idle();
    for (int k = 0; k < 4; k++) step();
    drv(1, 1, 1, 1, 32'h0);
    step();
    drv(1, 1, 1, 0, 32'h0000_0003);
    step();
    chk("b_rd_prewr", bus.cslDATAO, 32'h0000_0103);
    drv(1, 0, 1, 1, 0);
    step();
    chk("b_pend_clr", bus.cslDATAO, 32'h0);
    idle();
    seen = '0;
    for (int k = 0; k < 20; k++) begin
      step();
      seen |= rpMOL;
    end
    chk("b_never_on", {24'h0, seen}, 32'h0);

    // Rewriting the same request mid-spin does not restart it
    drv(1, 1, 0, 0, 32'h0000_0103);
    step();
    n0 = cyc;
    idle();
    for (int k = 0; k < 3; k++) step();
    drv(1, 1, 0, 0, 32'h0000_0103);
    step();
    idle();
    wait_rise(at);
    chk("c_rise_lat", at - n0, 11);
    drv(1, 1, 0, 0, 32'h0000_0100);
    step();
    chk("c_dpr0_mol", {24'h0, rpMOL}, 32'h0);
    chk("c_dpr0", {24'h0, rpDPR}, 32'h0);

    // Reset during spin-up
    drv(1, 1, 0, 0, 32'h0080_0103);
    step();
    idle();
    for (int k = 0; k < 3; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("d_dpr", {24'h0, rpDPR}, 32'h1);
    chk("d_mol", {24'h0, rpMOL}, 32'h0);
    chk("d_wrl", {24'h0, rpWRL}, 32'h0);
    chk("d_do", bus.cslDATAO, 32'h0);
    seen = '0;
    for (int k = 0; k < 15; k++) begin
      step();
      seen |= rpMOL;
    end
    chk("d_stay_off", {24'h0, seen}, 32'h0);
    drv(1, 0, 1, 0, 0);
    step();
    chk("d_ctl", bus.cslDATAO, 32'h1);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      drv($urandom_range(0, 3) != 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 1) == 1,
          2'($urandom_range(0, 3)),
          $urandom());
      dbg = {$urandom(), $urandom()};
      rst_n = ($urandom_range(0, 150) != 0);
      step();
    end
    rst_n = 1'b1;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
